// File: rtl/m_wbarb2.sv
// rtl/m_wbarb2.sv - two-master Wishbone classic arbiter with round-robin grant and bus-timeout watchdog
//
// Purpose: shares one Wishbone slave port between master 0 (core bus) and
// master 1 (loader/debug). Grant is round-robin, held for the whole CYC, and a
// strobe the slave never acknowledges is ended with ERR by a watchdog.
//
// Ports:
//   CLK_I, RST_I            clock, asynchronous active-low reset
//   M0_* / M1_*             master-side Wishbone (CYC/STB/WE/ADR/DAT/SEL in,
//                           ACK/ERR/DAT out)
//   S_*                     slave-side Wishbone (CYC/STB/WE/ADR/DAT/SEL out,
//                           ACK/DAT in)
//   gnt                     one-hot current grant, 00 when idle
//   timeout                 one-cycle pulse when the watchdog fires
module m_wbarb2 #(
    parameter int TIMEOUT = 255,
    parameter int TOWIDTH = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    input  logic [3:0]  M0_SEL_I,
    output logic        M0_ACK_O,
    output logic        M0_ERR_O,
    output logic [31:0] M0_DAT_O,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    input  logic [3:0]  M1_SEL_I,
    output logic        M1_ACK_O,
    output logic        M1_ERR_O,
    output logic [31:0] M1_DAT_O,
    output logic        S_CYC_O,
    output logic        S_STB_O,
    output logic        S_WE_O,
    output logic [31:0] S_ADR_O,
    output logic [31:0] S_DAT_O,
    output logic [3:0]  S_SEL_O,
    input  logic        S_ACK_I,
    input  logic [31:0] S_DAT_I,
    output logic [1:0]  gnt,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [TOWIDTH-1:0] TO_LAST = TO_EN ? TOWIDTH'(TIMEOUT - 1) : '0;

    state_t             state_q, state_d;
    logic               last_q, last_d;     // 0: master 0 was last, 1: master 1
    logic [TOWIDTH-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;       // watchdog armed for this cycle
    logic               hold;
    logic               stall;
    logic               fire;

    // Grant FSM: round-robin from idle, locked while the owner holds CYC,
    // direct handover when the other master is already waiting.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (M0_CYC_I) begin
                    state_d = ST_GNT0;
                end else if (M1_CYC_I) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!M0_CYC_I) begin
                    last_d  = 1'b0;
                    state_d = M1_CYC_I ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!M1_CYC_I) begin
                    last_d  = 1'b1;
                    state_d = M0_CYC_I ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave mux; STB is withheld in the cycle the watchdog ends the strobe.
    always_comb begin
        S_CYC_O = 1'b0;
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        S_SEL_O = '0;
        case (state_q)
            ST_GNT0: begin
                S_CYC_O = M0_CYC_I;
                S_STB_O = M0_STB_I & ~err_q;
                S_WE_O  = M0_WE_I;
                S_ADR_O = M0_ADR_I;
                S_DAT_O = M0_DAT_I;
                S_SEL_O = M0_SEL_I;
            end
            ST_GNT1: begin
                S_CYC_O = M1_CYC_I;
                S_STB_O = M1_STB_I & ~err_q;
                S_WE_O  = M1_WE_I;
                S_ADR_O = M1_ADR_I;
                S_DAT_O = M1_DAT_I;
                S_SEL_O = M1_SEL_I;
            end
            default: ;
        endcase
    end

    // Watchdog: count un-ACKed strobe cycles while the grant is stable; any
    // ACK, STB drop, grant change or ERR restarts from zero.
    always_comb begin
        hold  = (state_q != ST_IDLE) && (state_d == state_q);
        stall = hold && S_STB_O && !S_ACK_I;
        err_d = TO_EN && stall && (cnt_q == TO_LAST);
        cnt_d = (TO_EN && stall) ? cnt_q + TOWIDTH'(1) : '0;
    end

    // A late ACK in the ERR cycle takes precedence over the error.
    assign fire     = err_q & ~S_ACK_I;
    assign timeout  = fire;
    assign M0_ERR_O = fire & (state_q == ST_GNT0);
    assign M1_ERR_O = fire & (state_q == ST_GNT1);
    assign M0_ACK_O = S_ACK_I & (state_q == ST_GNT0);
    assign M1_ACK_O = S_ACK_I & (state_q == ST_GNT1);
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;
    assign gnt      = {state_q == ST_GNT1, state_q == ST_GNT0};

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_m_wbarb2.sv
// tb/tb_m_wbarb2.sv - directed self-checking bench for m_wbarb2
module tb_m_wbarb2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_dat = 0;
    logic [3:0]  m0_sel = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_dat = 0;
    logic [3:0]  m1_sel = 0;
    logic        s_ack = 0;
    logic [31:0] s_dat = 0;

    logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, tmo;
    logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we, z_tmo;
    logic [31:0] z_m0_rdat, z_m1_rdat, z_s_adr, z_s_wdat;
    logic [3:0]  z_s_sel;
    logic [1:0]  z_gnt;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_wbarb2 #(.TIMEOUT(4), .TOWIDTH(8)) u_dut (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
        .M0_DAT_I(m0_dat), .M0_SEL_I(m0_sel), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
        .M0_DAT_O(m0_rdat),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
        .M1_DAT_I(m1_dat), .M1_SEL_I(m1_sel), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
        .M1_DAT_O(m1_rdat),
        .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr),
        .S_DAT_O(s_wdat), .S_SEL_O(s_sel), .S_ACK_I(s_ack), .S_DAT_I(s_dat),
        .gnt(gnt), .timeout(tmo)
    );

    m_wbarb2 #(.TIMEOUT(0), .TOWIDTH(8)) u_dut0 (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
        .M0_DAT_I(m0_dat), .M0_SEL_I(m0_sel), .M0_ACK_O(z_m0_ack), .M0_ERR_O(z_m0_err),
        .M0_DAT_O(z_m0_rdat),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
        .M1_DAT_I(m1_dat), .M1_SEL_I(m1_sel), .M1_ACK_O(z_m1_ack), .M1_ERR_O(z_m1_err),
        .M1_DAT_O(z_m1_rdat),
        .S_CYC_O(z_s_cyc), .S_STB_O(z_s_stb), .S_WE_O(z_s_we), .S_ADR_O(z_s_adr),
        .S_DAT_O(z_s_wdat), .S_SEL_O(z_s_sel), .S_ACK_I(s_ack), .S_DAT_I(s_dat),
        .gnt(z_gnt), .timeout(z_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_m0();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
    endtask

    task automatic clr_m1();
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
    endtask

    initial begin
        int   nerr4;
        logic seen0;

        // Reset: slave side and returns stay quiet even with requests present
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h1234_5678; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; s_ack = 1;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_sstb", 32'(s_stb), 0);
        chk("rst_sadr", s_adr, 0);
        chk("rst_m0ack", 32'(m0_ack), 0);
        chk("rst_m1ack", 32'(m1_ack), 0);
        chk("rst_m0err", 32'(m0_err), 0);
        clr_m0(); clr_m1(); s_ack = 0;
        tick();
        rst_n = 1;

        // M0 only write
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h4000_0004;
        m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
        #1;
        chk("t1_gnt_pre", 32'(gnt), 0);
        chk("t1_scyc_pre", 32'(s_cyc), 0);
        tick(); #1;
        chk("t1_gnt", 32'(gnt), 1);
        chk("t1_scyc", 32'(s_cyc), 1);
        chk("t1_sstb", 32'(s_stb), 1);
        chk("t1_swe", 32'(s_we), 1);
        chk("t1_sadr", s_adr, 32'h4000_0004);
        chk("t1_sdat", s_wdat, 32'hDEAD_BEEF);
        chk("t1_ssel", 32'(s_sel), 32'hF);
        chk("t1_m0ack_pre", 32'(m0_ack), 0);
        tick();
        s_ack = 1; s_dat = 32'hCAFE_F00D;
        #1;
        chk("t1_m0ack", 32'(m0_ack), 1);
        chk("t1_m1ack", 32'(m1_ack), 0);
        chk("t1_m0rdat", m0_rdat, 32'hCAFE_F00D);
        chk("t1_m0err", 32'(m0_err), 0);
        tick();
        s_ack = 0; clr_m0();
        #1;
        chk("t1_gnt_hold", 32'(gnt), 1);
        chk("t1_scyc_drop", 32'(s_cyc), 0);
        tick(); #1;
        chk("t1_gnt_idle", 32'(gnt), 0);

        // Simultaneous request after reset, handover, alternation
        rst_n = 0; #2; rst_n = 1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        tick(); #1;
        chk("t2_gnt_m0", 32'(gnt), 1);
        chk("t2_sadr_m0", s_adr, 32'h100);
        s_ack = 1; #1;
        chk("t2_m0ack", 32'(m0_ack), 1);
        chk("t2_m1ack_blk", 32'(m1_ack), 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("t2_gnt_still", 32'(gnt), 1);
        tick(); #1;
        chk("t2_gnt_m1", 32'(gnt), 2);
        chk("t2_sadr_m1", s_adr, 32'h200);
        chk("t2_scyc_m1", 32'(s_cyc), 1);
        s_ack = 1; #1;
        chk("t2_m1ack", 32'(m1_ack), 1);
        chk("t2_m0ack_blk", 32'(m0_ack), 0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick(); #1;
        chk("t2_gnt_idle", 32'(gnt), 0);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick(); #1;
        chk("t2_alt_m0", 32'(gnt), 1);
        clr_m0(); clr_m1();
        tick();

        // Locked cycle: M1 wins round-robin, keeps CYC over 3 strobes
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600;
        #1;
        chk("t3_gnt_pre", 32'(gnt), 0);
        tick(); #1;
        chk("t3_rr_m1", 32'(gnt), 2);
        for (int i = 0; i < 3; i++) begin
            s_ack = 1; #1;
            chk("t3_lock_gnt", 32'(gnt), 2);
            chk("t3_lock_m1ack", 32'(m1_ack), 1);
            chk("t3_lock_m0ack", 32'(m0_ack), 0);
            tick();
        end
        s_ack = 0; clr_m1();
        #1;
        chk("t3_gnt_tail", 32'(gnt), 2);
        tick(); #1;
        chk("t3_gnt_m0", 32'(gnt), 1);
        chk("t3_sadr_m0", s_adr, 32'h500);
        clr_m0();
        tick();

        // Watchdog, TIMEOUT=4
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
        tick(); #1;
        for (int j = 0; j < 4; j++) begin
            chk("t4_noerr", 32'(m0_err), 0);
            chk("t4_stb", 32'(s_stb), 1);
            tick(); #1;
        end
        chk("t4_err", 32'(m0_err), 1);
        chk("t4_tmo", 32'(tmo), 1);
        chk("t4_stb_forced", 32'(s_stb), 0);
        chk("t4_m1err", 32'(m1_err), 0);
        chk("t4_m0ack", 32'(m0_ack), 0);
        tick();
        m0_stb = 0; #1;
        chk("t4_err_pulse", 32'(m0_err), 0);
        chk("t4_tmo_pulse", 32'(tmo), 0);
        tick();
        m0_stb = 1; #1;
        for (int j = 0; j < 4; j++) begin
            chk("t4_re_noerr", 32'(m0_err), 0);
            tick(); #1;
        end
        chk("t4_re_err", 32'(m0_err), 1);
        tick();
        m0_stb = 0;
        tick();
        m0_stb = 1; #1;
        for (int j = 0; j < 4; j++) begin
            chk("t4_race_noerr", 32'(m0_err), 0);
            tick(); #1;
        end
        s_ack = 1; #1;
        chk("t4_race_ack", 32'(m0_ack), 1);
        chk("t4_race_err", 32'(m0_err), 0);
        chk("t4_race_tmo", 32'(tmo), 0);
        tick();
        s_ack = 0; clr_m0();
        tick();

        // 1000-cycle stall: TIMEOUT=0 never fires, TIMEOUT=4 fires every 5 cycles
        m0_cyc = 1; m0_stb = 1;
        tick(); #1;
        nerr4 = 0;
        seen0 = 0;
        for (int i = 0; i < 1000; i++) begin
            seen0 = seen0 | z_m0_err | z_tmo | ~z_s_stb;
            nerr4 += int'(m0_err);
            tick(); #1;
        end
        chk("t5_to0_quiet", 32'(seen0), 0);
        chk("t5_to4_count", 32'(nerr4), 200);
        clr_m0();
        tick();
        tick();

        // Asynchronous reset during GNT1
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h900;
        tick(); #1;
        chk("t6_gnt_m1", 32'(gnt), 2);
        chk("t6_sadr", s_adr, 32'h900);
        s_ack = 1; #1;
        chk("t6_m1ack", 32'(m1_ack), 1);
        rst_n = 0; #1;
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_scyc", 32'(s_cyc), 0);
        chk("t6_rst_sstb", 32'(s_stb), 0);
        chk("t6_rst_sadr", s_adr, 0);
        chk("t6_rst_m1ack", 32'(m1_ack), 0);
        chk("t6_rst_z_gnt", 32'(z_gnt), 0);
        rst_n = 1; s_ack = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA00;
        tick(); #1;
        chk("t6_after_m0", 32'(gnt), 1);
        chk("t6_after_sadr", s_adr, 32'hA00);
        clr_m0(); clr_m1();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
